round_encrypt: RTL and testbench
================================

# round_encrypt

Single-round SPECK encryption engine, the forward counterpart of the round decryptor. Takes a 2-word plaintext and one round subkey and produces the 2-word ciphertext of one SPECK round. It uses a multi-cycle state machine with a level start/finished handshake. It sits under the key-schedule/round controller, which iterates it once per round and feeds each round's ciphertext back as the next plaintext.

## Interface
Parameters:
- BLOCK_SIZE, 16, word width n (SPECK32/64 default).
- SHIFT_WIDTH_P0, 7, rotate amount alpha applied to word p0.
- SHIFT_WIDTH_P1, 2, rotate amount beta applied to word p1.
- KEY_SIZE, 2*BLOCK_SIZE, full block width (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- subkey  in  BLOCK_SIZE  round key k, captured at start.
- plaintext  in  KEY_SIZE  input block; [BLOCK_SIZE-1:0] = p0 (x word), [KEY_SIZE-1:BLOCK_SIZE] = p1 (y word); captured at start.
- signal_start  in  1  level request; sampled in IDLE and DONE.
- ciphertext  out  KEY_SIZE  registered result, same word layout as plaintext.
- finished  out  1  result valid; registered.
- state_response  out  4  current state encoding, debug only.

## Operation
- Round function, all arithmetic modulo 2^BLOCK_SIZE:
  - p0 = ((p0 ROR alpha) + p1) XOR k
  - p1 = (p1 ROL beta) XOR p0_new
- Rotates are true rotates, with no bits lost. The add discards the carry out.
- States and encodings:
  - IDLE (0): finished = 0. If signal_start = 1, capture p0, p1 and k into internal registers and go to ROT. Otherwise stay.
  - ROT (1): p0 <= p0 ROR SHIFT_WIDTH_P0.
  - ADD (2): p0 <= p0 + p1; p1 <= p1 ROL SHIFT_WIDTH_P1.
  - XOR_K (3): p0 <= p0 XOR k.
  - XOR_P1 (4): p1 <= p1 XOR p0.
  - OUT (5): ciphertext <= {p1, p0}; finished <= 1.
  - DONE (6): hold ciphertext and finished. When signal_start = 0, finished <= 0 and go to IDLE.
- State transitions: ROT through OUT advance unconditionally, one state per cycle.
- Encodings 7–15 are illegal. If reached, go to IDLE with finished <= 0.
- Plaintext, subkey and signal_start changes after capture are ignored until DONE.
- ciphertext keeps its last value through IDLE and the next computation; it is only updated in OUT.

## Timing
- Reset (rst_n = 0 at an edge): state = IDLE, finished = 0, ciphertext = 0, internal p0/p1/k = 0.
- Reset has priority over every state. Asserting it mid-operation aborts the round: no finished pulse and no ciphertext update.
- Latency: signal_start seen high at edge N (in IDLE) gives valid ciphertext and finished = 1 after edge N+5.
- finished then stays high until the first edge with signal_start = 0. It falls after that edge, and state returns to IDLE in the same edge.
- Back-to-back rounds: the controller drops start for at least one cycle, then raises it again. The minimum period is 7 cycles: 1 in IDLE, 5 computing, 1 in DONE with start low.
- If signal_start is held high continuously, the block stays in DONE and does not restart.
- state_response is updated on the same edge as the state register, with no extra delay.

## Test plan
- Known vector (SPECK32/64 round 0): plaintext = 0x694C6574, subkey = 0x0100, start → after 5 cycles ciphertext = 0xF6275316, finished = 1, state_response = 6.
- Carry wrap: plaintext = 0x0001FFFF, subkey = 0x0000 → ciphertext = 0x00040000.
- Handshake:
  - Hold start high 10 cycles → finished stays 1, ciphertext stable, no recompute.
  - Drop start → finished = 0 and state = 0 after the next edge.
  - Restart with new inputs → new result 5 cycles after it is sampled.
- Input change after capture: change plaintext and subkey in every cycle ROT..XOR_P1 during the known-vector run → result still 0xF6275316.
- Reset mid-operation: assert rst_n = 0 in state ADD → next cycle state = 0, finished = 0, ciphertext = 0. Deassert and rerun the known vector → correct result.
- Round-trip with the decryptor: 1000 random plaintext/subkey pairs through encrypt then decrypt, same subkey → recovered block equals the original plaintext.

Source files
------------

// File: rtl/round_encrypt.sv
// One SPECK encryption round, computed over five sequenced cycles.
// A level start/finished handshake lets a round controller step it once per round.
module round_encrypt #(
    parameter int BLOCK_SIZE     = 16,
    parameter int SHIFT_WIDTH_P0 = 7,
    parameter int SHIFT_WIDTH_P1 = 2,
    parameter int KEY_SIZE       = 2 * BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BLOCK_SIZE-1:0] subkey,
    input  logic [KEY_SIZE-1:0]   plaintext,
    input  logic                  signal_start,
    output logic [KEY_SIZE-1:0]   ciphertext,
    output logic                  finished,
    output logic [3:0]            state_response
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ROT    = 4'd1,
        S_ADD    = 4'd2,
        S_XOR_K  = 4'd3,
        S_XOR_P1 = 4'd4,
        S_OUT    = 4'd5,
        S_DONE   = 4'd6
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [BLOCK_SIZE-1:0] r_p0;
    logic [BLOCK_SIZE-1:0] r_p1;
    logic [BLOCK_SIZE-1:0] r_k;
    logic [KEY_SIZE-1:0]   r_ciphertext;
    logic                  r_finished;
    logic [BLOCK_SIZE-1:0] w_p0Ror;
    logic [BLOCK_SIZE-1:0] w_p1Rol;

    assign w_p0Ror = (r_p0 >> SHIFT_WIDTH_P0) | (r_p0 << (BLOCK_SIZE - SHIFT_WIDTH_P0));
    assign w_p1Rol = (r_p1 << SHIFT_WIDTH_P1) | (r_p1 >> (BLOCK_SIZE - SHIFT_WIDTH_P1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The compute steps advance unconditionally; only IDLE and DONE watch the start level.
    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:   w_nextState = signal_start ? S_ROT : S_IDLE;
            S_ROT:    w_nextState = S_ADD;
            S_ADD:    w_nextState = S_XOR_K;
            S_XOR_K:  w_nextState = S_XOR_P1;
            S_XOR_P1: w_nextState = S_OUT;
            S_OUT:    w_nextState = S_DONE;
            S_DONE:   w_nextState = signal_start ? S_DONE : S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p0         <= '0;
            r_p1         <= '0;
            r_k          <= '0;
            r_ciphertext <= '0;
            r_finished   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_finished <= 1'b0;
                    if (signal_start) begin
                        r_p0 <= plaintext[BLOCK_SIZE-1:0];
                        r_p1 <= plaintext[KEY_SIZE-1:BLOCK_SIZE];
                        r_k  <= subkey;
                    end
                end
                S_ROT: begin
                    r_p0 <= w_p0Ror;
                end
                S_ADD: begin
                    r_p0 <= r_p0 + r_p1;
                    r_p1 <= w_p1Rol;
                end
                S_XOR_K: begin
                    r_p0 <= r_p0 ^ r_k;
                end
                S_XOR_P1: begin
                    r_p1 <= r_p1 ^ r_p0;
                end
                S_OUT: begin
                    r_ciphertext <= {r_p1, r_p0};
                    r_finished   <= 1'b1;
                end
                S_DONE: begin
                    if (!signal_start) begin
                        r_finished <= 1'b0;
                    end
                end
                default: begin
                    r_finished <= 1'b0;
                end
            endcase
        end
    end

    assign ciphertext     = r_ciphertext;
    assign finished       = r_finished;
    assign state_response = r_state;

endmodule

// File: tb/tb_round_encrypt.sv
// Directed bench for round_encrypt: known vectors, handshake, reset abort,
// plus a random round trip through a software inverse round.
module tb_round_encrypt;

    logic        clk;
    logic        rst_n;
    logic [15:0] subkey;
    logic [31:0] plaintext;
    logic        signal_start;
    logic [31:0] ciphertext;
    logic        finished;
    logic [3:0]  state_response;

    int assertCount;
    int failCount;
    int cycles;
    logic [31:0] heldCipher;
    logic [31:0] randPt;
    logic [15:0] randKey;

    round_encrypt dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .subkey         (subkey),
        .plaintext      (plaintext),
        .signal_start   (signal_start),
        .ciphertext     (ciphertext),
        .finished       (finished),
        .state_response (state_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Raises start from IDLE and waits, bounded, for finished; reports edges taken.
    task automatic applyStimulus(input logic [31:0] pt, input logic [15:0] key, output int edgesTaken);
        plaintext    = pt;
        subkey       = key;
        signal_start = 1'b1;
        edgesTaken   = 0;
        do begin
            stepEdge();
            edgesTaken++;
        end while (!finished && edgesTaken < 20);
    endtask

    task automatic dropStart();
        signal_start = 1'b0;
        stepEdge();
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    // Inverse SPECK round, as the decryptor would compute it.
    function automatic logic [31:0] decryptModel(input logic [31:0] c, input logic [15:0] k);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] yPrev;
        logic [15:0] xPrev;
        x     = c[15:0];
        y     = c[31:16];
        yPrev = ror16(y ^ x, 2);
        xPrev = rol16(16'((x ^ k) - yPrev), 7);
        return {yPrev, xPrev};
    endfunction

    initial begin
        assertCount  = 0;
        failCount    = 0;
        rst_n        = 1'b0;
        signal_start = 1'b0;
        plaintext    = 32'h0;
        subkey       = 16'h0;
        stepEdge();
        stepEdge();
        checkOutput("reset_state", {28'h0, state_response}, 32'd0);
        checkOutput("reset_finished", {31'h0, finished}, 32'd0);
        checkOutput("reset_cipher", ciphertext, 32'h0);

        rst_n = 1'b1;
        stepEdge();
        checkOutput("idle_state", {28'h0, state_response}, 32'd0);

        // Known vector, inputs scrambled every compute cycle after capture.
        plaintext    = 32'h694C6574;
        subkey       = 16'h0100;
        signal_start = 1'b1;
        stepEdge();
        checkOutput("rot_state", {28'h0, state_response}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            plaintext = $urandom;
            subkey    = 16'($urandom);
            stepEdge();
        end
        checkOutput("out_state", {28'h0, state_response}, 32'd5);
        checkOutput("not_early_finished", {31'h0, finished}, 32'd0);
        stepEdge();
        checkOutput("kv_cipher", ciphertext, 32'hF6275316);
        checkOutput("kv_finished", {31'h0, finished}, 32'd1);
        checkOutput("kv_state", {28'h0, state_response}, 32'd6);

        // Start held high: stay in DONE, result stable.
        for (int i = 0; i < 10; i++) begin
            stepEdge();
            checkOutput("hold_finished", {31'h0, finished}, 32'd1);
            checkOutput("hold_cipher", ciphertext, 32'hF6275316);
            checkOutput("hold_state", {28'h0, state_response}, 32'd6);
        end

        dropStart();
        checkOutput("drop_finished", {31'h0, finished}, 32'd0);
        checkOutput("drop_state", {28'h0, state_response}, 32'd0);
        checkOutput("idle_keeps_cipher", ciphertext, 32'hF6275316);

        applyStimulus(32'h00000001, 16'hFFFF, cycles);
        checkOutput("restart_latency", cycles, 32'd6);
        checkOutput("restart_cipher", ciphertext, 32'hFDFFFDFF);
        dropStart();

        applyStimulus(32'h0001FFFF, 16'h0000, cycles);
        checkOutput("carry_latency", cycles, 32'd6);
        checkOutput("carry_cipher", ciphertext, 32'h00040000);
        dropStart();

        // Reset while in ADD aborts the round.
        plaintext    = 32'h694C6574;
        subkey       = 16'h0100;
        signal_start = 1'b1;
        stepEdge();
        stepEdge();
        checkOutput("add_state", {28'h0, state_response}, 32'd2);
        rst_n        = 1'b0;
        signal_start = 1'b0;
        stepEdge();
        checkOutput("abort_state", {28'h0, state_response}, 32'd0);
        checkOutput("abort_finished", {31'h0, finished}, 32'd0);
        checkOutput("abort_cipher", ciphertext, 32'h0);
        rst_n = 1'b1;
        stepEdge();
        applyStimulus(32'h694C6574, 16'h0100, cycles);
        checkOutput("rerun_latency", cycles, 32'd6);
        checkOutput("rerun_cipher", ciphertext, 32'hF6275316);
        dropStart();

        for (int i = 0; i < 1000; i++) begin
            randPt  = $urandom;
            randKey = 16'($urandom);
            applyStimulus(randPt, randKey, cycles);
            checkOutput("roundtrip_finished", {31'h0, finished}, 32'd1);
            checkOutput("roundtrip_plain", decryptModel(ciphertext, randKey), randPt);
            dropStart();
        end

        heldCipher = ciphertext;
        stepEdge();
        checkOutput("final_idle_cipher", ciphertext, heldCipher);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
